// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the WaveRV multiport register file.
package register_file_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned REG_COUNT_DEFAULT  = 32;
  localparam int unsigned ZERO_ADDRESS       = 0;
  // Widest datum even_parity accepts; callers zero-extend, which leaves parity unchanged.
  localparam int unsigned PARITY_MAX_WIDTH   = 256;

  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// Per-register busy bits: issue marks a pending producer, writeback clears it.
// Lookups return the post-edge state so they line up with bypassed read data.
module register_file_scoreboard
  import register_file_pkg::*;
#(
  parameter int unsigned REG_COUNT      = REG_COUNT_DEFAULT,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned ADDR_WIDTH     = $clog2(REG_COUNT)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             issue_en_i,
  input  logic [ADDR_WIDTH-1:0]            issue_addr_i,
  input  logic                             clear_en_i,
  input  logic [ADDR_WIDTH-1:0]            clear_addr_i,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] lookup_addr_i,
  output logic [NUM_READ_PORTS-1:0]        lookup_busy_o
);

  logic [REG_COUNT-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (clear_en_i) begin
      busy_d[clear_addr_i] = 1'b0;
    end
    if (issue_en_i && (issue_addr_i != ADDR_WIDTH'(ZERO_ADDRESS))) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[ZERO_ADDRESS] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    lookup_busy_o = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      lookup_busy_o[p] = busy_d[lookup_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

endmodule

// File: rtl/register_file_multiport.sv
// N-read/1-write register file with write-before-read bypass, x0 hardwired to zero and busy
// tracking. Define RF_PARITY_EN to store an even-parity bit per entry and flag mismatches on read.
module register_file_multiport
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int unsigned REG_COUNT      = REG_COUNT_DEFAULT,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned ADDR_WIDTH     = $clog2(REG_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 register_write_enable,
  input  logic [ADDR_WIDTH-1:0]                register_write_address,
  input  logic [DATA_WIDTH-1:0]                register_write_data,
  input  logic                                 register_issue_enable,
  input  logic [ADDR_WIDTH-1:0]                register_issue_address,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] register_read_address,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] register_read_data,
  output logic [NUM_READ_PORTS-1:0]            register_read_busy,
  output logic [NUM_READ_PORTS-1:0]            register_parity_error
);

  logic                  write_ok;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [NUM_READ_PORTS-1:0] lookup_busy;

  assign write_ok = register_write_enable &&
                    (register_write_address != ADDR_WIDTH'(ZERO_ADDRESS));

  // Entry 0 is never written, so it reads back as zero without special casing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else if (write_ok) begin
      regs_q[register_write_address] <= register_write_data;
    end
  end

`ifdef RF_PARITY_EN
  logic [REG_COUNT-1:0] par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else if (write_ok) begin
      par_q[register_write_address] <= even_parity(PARITY_MAX_WIDTH'(register_write_data));
    end
  end
`endif

  register_file_scoreboard #(
    .REG_COUNT      (REG_COUNT),
    .NUM_READ_PORTS (NUM_READ_PORTS),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_scoreboard (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .issue_en_i    (register_issue_enable),
    .issue_addr_i  (register_issue_address),
    .clear_en_i    (write_ok),
    .clear_addr_i  (register_write_address),
    .lookup_addr_i (register_read_address),
    .lookup_busy_o (lookup_busy)
  );

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : gen_read
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
    logic                  perr_d, perr_q, busy_q;

    assign raddr = register_read_address[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      bypass  = write_ok && (register_write_address == raddr);
      rdata_d = bypass ? register_write_data : regs_q[raddr];
      perr_d  = 1'b0;
`ifdef RF_PARITY_EN
      // Only stored data is checked; bypassed data has not been through storage.
      perr_d  = !bypass && (raddr != ADDR_WIDTH'(ZERO_ADDRESS)) &&
                (even_parity(PARITY_MAX_WIDTH'(regs_q[raddr])) != par_q[raddr]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
        perr_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        rdata_q <= rdata_d;
        perr_q  <= perr_d;
        busy_q  <= lookup_busy[p];
      end
    end

    assign register_read_data[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    assign register_read_busy[p]                          = busy_q;
    assign register_parity_error[p]                       = perr_q;
  end

endmodule

// File: tb/tb_register_file_multiport.sv
// Scoreboard bench for register_file_multiport: stimulus queues expected read results,
// a negedge monitor pops and compares them.
module tb_register_file_multiport;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        ie;
  logic [4:0]  ia;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  perr;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic [1:0]  perr;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  register_file_multiport dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .register_write_enable  (we),
    .register_write_address (wa),
    .register_write_data    (wd),
    .register_issue_enable  (ie),
    .register_issue_address (ia),
    .register_read_address  (raddr),
    .register_read_data     (rdata),
    .register_read_busy     (rbusy),
    .register_parity_error  (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".data0"}, rdata[31:0], e.d0);
      chk({e.tag, ".data1"}, rdata[63:32], e.d1);
      chk({e.tag, ".busy"}, 32'(rbusy), 32'(e.busy));
      chk({e.tag, ".perr"}, 32'(perr), 32'(e.perr));
    end
  end

  // Drives one cycle of inputs; if chk_en, the result seen after this edge is queued.
  task automatic step(input logic w_en, input logic [4:0] w_a, input logic [31:0] w_d,
                      input logic i_en, input logic [4:0] i_a,
                      input logic [4:0] r0, input logic [4:0] r1, input bit chk_en,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [1:0] eb, input logic [1:0] ep, input string tag);
    exp_t e;
    we = w_en; wa = w_a; wd = w_d; ie = i_en; ia = i_a; raddr = {r1, r0};
    @(posedge clk);
    if (chk_en) begin
      e.d0 = e0; e.d1 = e1; e.busy = eb; e.perr = ep; e.tag = tag;
      exp_q.push_back(e);
    end
    #1;
    we = 1'b0; ie = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".data0"}, rdata[31:0], 32'h0);
    chk({tag, ".data1"}, rdata[63:32], 32'h0);
    chk({tag, ".busy"}, 32'(rbusy), 32'h0);
    chk({tag, ".perr"}, 32'(perr), 32'h0);
  endtask

`ifdef RF_PARITY_EN
  logic [31:0] par_snap;
`endif

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ie = 1'b0; ia = '0; raddr = '0;
    #3;
    chk_zero_outputs("reset_initial");
    #9 rst_n = 1'b1;

    // Reset mid-cycle clears outputs before the next edge and wipes storage.
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 2'b00,
         "pre_reset_x5");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 5'd5, 5'd5, 1, 32'h0, 32'h0, 2'b00, 2'b00, "post_reset_x5");

    // Write then read on both ports.
    step(1, 5'd7, 32'h12345678, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 0, 0, 5'd7, 5'd7, 1, 32'h12345678, 32'h12345678, 2'b00, 2'b00, "read_x7");

    // Bypass: same-cycle write must beat the stored value.
    step(1, 5'd3, 32'h11111111, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, "");
    step(1, 5'd3, 32'hA5A5A5A5, 0, 0, 5'd3, 5'd7, 1, 32'hA5A5A5A5, 32'h12345678, 2'b00, 2'b00,
         "bypass_x3");
    step(0, 0, 0, 0, 0, 5'd7, 5'd3, 1, 32'h12345678, 32'hA5A5A5A5, 2'b00, 2'b00, "stored_x3");

    // x0 ignores writes and issues.
    step(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd0, 1, 32'h0, 32'h0, 2'b00, 2'b00, "x0_same");
    step(0, 0, 0, 0, 0, 5'd0, 5'd7, 1, 32'h0, 32'h12345678, 2'b00, 2'b00, "x0_after");

    // Scoreboard set, clear, and set-wins-over-clear.
    step(0, 0, 0, 1, 5'd9, 5'd9, 5'd9, 1, 32'h0, 32'h0, 2'b11, 2'b00, "issue_x9");
    step(0, 0, 0, 0, 0, 5'd9, 5'd7, 1, 32'h0, 32'h12345678, 2'b01, 2'b00, "busy_x9_held");
    step(1, 5'd9, 32'hCAFEF00D, 0, 0, 5'd9, 5'd9, 1, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 2'b00,
         "write_clears_x9");
    step(0, 0, 0, 0, 0, 5'd7, 5'd9, 1, 32'h12345678, 32'hCAFEF00D, 2'b00, 2'b00, "idle_x9");
    step(1, 5'd9, 32'h0BADC0DE, 1, 5'd9, 5'd9, 5'd3, 1, 32'h0BADC0DE, 32'hA5A5A5A5, 2'b01,
         2'b00, "issue_wins_x9");
    step(0, 0, 0, 0, 0, 5'd3, 5'd9, 1, 32'hA5A5A5A5, 32'h0BADC0DE, 2'b10, 2'b00, "busy_x9_kept");

    // Parity flag.
    step(1, 5'd4, 32'h00000010, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 0, 0, 5'd4, 5'd4, 1, 32'h10, 32'h10, 2'b00, 2'b00, "parity_clean_x4");
`ifdef RF_PARITY_EN
    par_snap = dut.par_q ^ 32'h10;
    force dut.par_q = par_snap;
    step(0, 0, 0, 0, 0, 5'd4, 5'd0, 1, 32'h10, 32'h0, 2'b00, 2'b01, "parity_err_x4");
    release dut.par_q;
    step(1, 5'd4, 32'h00000010, 0, 0, 5'd4, 5'd4, 1, 32'h10, 32'h10, 2'b00, 2'b00,
         "parity_rewrite_x4");
    step(0, 0, 0, 0, 0, 5'd4, 5'd4, 1, 32'h10, 32'h10, 2'b00, 2'b00, "parity_fixed_x4");
`else
    step(0, 0, 0, 0, 0, 5'd4, 5'd9, 1, 32'h10, 32'h0BADC0DE, 2'b10, 2'b00, "parity_off_x4");
`endif

    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, "");
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
